// File: rtl/wall_column_sink.sv
// Consumer end of the wall-column interface: scrolls generator columns
// right-to-left through a playfield, decodes gaps, tests the bird, keeps score.
//
// Ports:
//   Clock, Reset  : system clock, synchronous active-high reset
//   tick          : one-cycle scroll strobe
//   start         : level, leaves IDLE when high
//   wall_in       : generator column, consumed when wall_req=1
//   bird_row      : bird row, sampled on tick
//   rd_col/rd_data: combinational playfield read port for the display
//   wall_req      : high on the tick cycle that consumes wall_in
//   gap_top/gap_len/pattern_err : decode of the last loaded column
//   collision     : sticky crash flag
//   score         : saturating count of columns passed
//   state         : 00 IDLE, 01 RUN, 10 CRASH
module wall_column_sink #(
    parameter int NUM_COLS = 16,
    parameter int BIRD_COL = 3,
    parameter int SPACING  = 6,
    parameter int SCORE_W  = 8
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic                        tick,
    input  logic                        start,
    input  logic [15:0]                 wall_in,
    input  logic [3:0]                  bird_row,
    input  logic [$clog2(NUM_COLS)-1:0] rd_col,
    output logic [15:0]                 rd_data,
    output logic                        wall_req,
    output logic [3:0]                  gap_top,
    output logic [4:0]                  gap_len,
    output logic                        pattern_err,
    output logic                        collision,
    output logic [SCORE_W-1:0]          score,
    output logic [1:0]                  state
);

    localparam int SW = (SPACING > 1) ? $clog2(SPACING) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        CRASH = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        col_q [NUM_COLS];
    logic [15:0]        col_d [NUM_COLS];
    logic [SW-1:0]      spawn_q, spawn_d;
    logic [3:0]         gap_top_q, gap_top_d;
    logic [4:0]         gap_len_q, gap_len_d;
    logic               pattern_err_q, pattern_err_d;
    logic               collision_q, collision_d;
    logic [SCORE_W-1:0] score_q, score_d;

    logic [15:0] zeros;
    logic [16:0] zeros_x;
    logic [16:0] low_bit;
    logic [4:0]  dec_len;
    logic [3:0]  dec_top;
    logic        dec_found;
    logic        dec_split;
    logic        dec_err;

    // Adding the lowest set bit to a single run of ones clears the whole
    // run; any bit that survives means a second, separate run exists.
    always_comb begin
        zeros     = ~wall_in;
        zeros_x   = {1'b0, zeros};
        low_bit   = zeros_x & (~zeros_x + 17'd1);
        dec_split = |((zeros_x + low_bit) & zeros_x);
        dec_len   = '0;
        dec_top   = '0;
        dec_found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            dec_len = dec_len + {4'd0, zeros[i]};
            if (zeros[i] && !dec_found) begin
                dec_top   = 4'(i);
                dec_found = 1'b1;
            end
        end
        dec_err = (dec_len == 5'd0) | dec_split;
    end

    logic        run_tick;
    logic        load;
    logic [15:0] arriving;
    logic        arriving_hit;

    assign run_tick     = tick & (state_q == RUN);
    assign load         = run_tick & (spawn_q == '0);
    // Pre-shift column about to land on the bird's column.
    assign arriving     = col_q[BIRD_COL+1];
    assign arriving_hit = arriving[bird_row];

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        spawn_d       = spawn_q;
        gap_top_d     = gap_top_q;
        gap_len_d     = gap_len_q;
        pattern_err_d = pattern_err_q;
        collision_d   = collision_q;
        score_d       = score_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (tick) begin
                    for (int i = 0; i < NUM_COLS - 1; i++) begin
                        col_d[i] = col_q[i+1];
                    end
                    if (load) begin
                        col_d[NUM_COLS-1] = wall_in;
                        spawn_d           = SW'(SPACING - 1);
                        gap_top_d         = dec_top;
                        gap_len_d         = dec_len;
                        pattern_err_d     = dec_err;
                    end else begin
                        col_d[NUM_COLS-1] = '0;
                        spawn_d           = spawn_q - SW'(1);
                    end
                    if (arriving != '0) begin
                        if (arriving_hit) begin
                            collision_d = 1'b1;
                            state_d     = CRASH;
                        end else if (score_q != '1) begin
                            score_d = score_q + SCORE_W'(1);
                        end
                    end
                end
            end
            CRASH: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            for (int i = 0; i < NUM_COLS; i++) begin
                col_q[i] <= '0;
            end
            spawn_q       <= '0;
            gap_top_q     <= '0;
            gap_len_q     <= '0;
            pattern_err_q <= 1'b0;
            collision_q   <= 1'b0;
            score_q       <= '0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            spawn_q       <= spawn_d;
            gap_top_q     <= gap_top_d;
            gap_len_q     <= gap_len_d;
            pattern_err_q <= pattern_err_d;
            collision_q   <= collision_d;
            score_q       <= score_d;
        end
    end

    assign rd_data     = col_q[rd_col];
    assign wall_req    = load;
    assign gap_top     = gap_top_q;
    assign gap_len     = gap_len_q;
    assign pattern_err = pattern_err_q;
    assign collision   = collision_q;
    assign score       = score_q;
    assign state       = state_q;

endmodule

// File: tb/tb_wall_column_sink.sv
// Self-checking bench for wall_column_sink: decode vector table with a
// scoreboard, plus spacing, crash, score saturation and reset sequences.
module tb_wall_column_sink;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        tick;
    logic        start;
    logic [15:0] wall_in;
    logic [3:0]  bird_row;
    logic [3:0]  rd_col;
    logic [15:0] rd_data;
    logic        wall_req;
    logic [3:0]  gap_top;
    logic [4:0]  gap_len;
    logic        pattern_err;
    logic        collision;
    logic [7:0]  score;
    logic [1:0]  state;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] wall;
        logic [3:0]  top;
        logic [4:0]  len;
        logic        err;
    } vec_t;

    typedef struct {
        logic [3:0]  top;
        logic [4:0]  len;
        logic        err;
        logic [15:0] col;
    } exp_t;

    vec_t vecs[10];
    exp_t sb[$];

    always #5 Clock = ~Clock;

    wall_column_sink dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .tick        (tick),
        .start       (start),
        .wall_in     (wall_in),
        .bird_row    (bird_row),
        .rd_col      (rd_col),
        .rd_data     (rd_data),
        .wall_req    (wall_req),
        .gap_top     (gap_top),
        .gap_len     (gap_len),
        .pattern_err (pattern_err),
        .collision   (collision),
        .score       (score),
        .state       (state)
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick  = 1'b0;
        start = 1'b0;
        step();
        step();
        Reset = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse(input logic [15:0] w, input logic exp_req,
                         input string nm);
        tick    = 1'b1;
        wall_in = w;
        #1;
        check(nm, 32'(wall_req), 32'(exp_req));
        step();
        tick = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        tick    = 1'b1;
        wall_in = 16'h1FFF;
        repeat (n) step();
        tick = 1'b0;
    endtask

    task automatic read_col(input int c, input logic [15:0] exp,
                            input string nm);
        rd_col = 4'(c);
        #1;
        check(nm, 32'(rd_data), 32'(exp));
    endtask

    task automatic check_field(input string nm, input logic [15:0] w3,
                               input logic [15:0] w9, input logic [15:0] w15);
        logic [15:0] e;
        for (int c = 0; c < 16; c++) begin
            e = (c == 3) ? w3 : (c == 9) ? w9 : (c == 15) ? w15 : 16'h0;
            read_col(c, e, nm);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t       e;
        logic [15:0] w;

        vecs[0] = '{16'hC7FF, 4'd11, 5'd3,  1'b0};
        vecs[1] = '{16'hF807, 4'd3,  5'd8,  1'b0};
        vecs[2] = '{16'hFFFF, 4'd0,  5'd0,  1'b1};
        vecs[3] = '{16'hAFFF, 4'd12, 5'd2,  1'b1};
        vecs[4] = '{16'h0000, 4'd0,  5'd16, 1'b0};
        vecs[5] = '{16'h1FFF, 4'd13, 5'd3,  1'b0};
        vecs[6] = '{16'h7FFE, 4'd0,  5'd2,  1'b1};
        vecs[7] = '{16'hFFFE, 4'd0,  5'd1,  1'b0};
        vecs[8] = '{16'h7FFF, 4'd15, 5'd1,  1'b0};
        vecs[9] = '{16'hF0F0, 4'd0,  5'd8,  1'b1};

        rd_col   = '0;
        wall_in  = '0;
        bird_row = '0;
        tick     = 1'b0;
        start    = 1'b0;
        Reset    = 1'b1;
        do_reset();

        check("rst_state", 32'(state), 32'd0);
        check("rst_score", 32'(score), 32'd0);
        check("rst_collision", 32'(collision), 32'd0);
        check("rst_gap_top", 32'(gap_top), 32'd0);
        check("rst_gap_len", 32'(gap_len), 32'd0);
        check("rst_pattern_err", 32'(pattern_err), 32'd0);
        check_field("rst_field", 16'h0, 16'h0, 16'h0);

        pulse(16'hFFFF, 1'b0, "idle_wall_req");
        check("idle_state", 32'(state), 32'd0);
        read_col(15, 16'h0, "idle_col15");

        start   = 1'b1;
        tick    = 1'b1;
        wall_in = 16'h1234;
        #1;
        check("st_tick_wall_req", 32'(wall_req), 32'd0);
        step();
        start = 1'b0;
        tick  = 1'b0;
        check("st_tick_state", 32'(state), 32'd1);
        check("st_tick_gap_len", 32'(gap_len), 32'd0);
        read_col(15, 16'h0, "st_tick_col15");

        foreach (vecs[i]) begin
            do_reset();
            go();
            bird_row = 4'd0;
            e.top = vecs[i].top;
            e.len = vecs[i].len;
            e.err = vecs[i].err;
            e.col = vecs[i].wall;
            sb.push_back(e);
            pulse(vecs[i].wall, 1'b1, "tbl_wall_req");
            e = sb.pop_front();
            check("tbl_gap_top", 32'(gap_top), 32'(e.top));
            check("tbl_gap_len", 32'(gap_len), 32'(e.len));
            check("tbl_pattern_err", 32'(pattern_err), 32'(e.err));
            read_col(15, e.col, "tbl_col15");
            read_col(14, 16'h0, "tbl_col14");
            pulse(16'h0F0F, 1'b0, "tbl_nospawn_req");
            check("tbl_hold_gap_top", 32'(gap_top), 32'(e.top));
            read_col(14, e.col, "tbl_shift_col14");
            read_col(15, 16'h0, "tbl_shift_col15");
        end

        do_reset();
        go();
        bird_row = 4'd14;
        for (int k = 0; k < 13; k++) begin
            w = (k == 0) ? 16'h1FFF : (k == 6) ? 16'h3FFF :
                (k == 12) ? 16'h0FFF : 16'hFFFF;
            pulse(w, (k % 6) == 0, "spc_wall_req");
            repeat (3) step();
        end
        check_field("spc_field", 16'h1FFF, 16'h3FFF, 16'h0FFF);
        check("spc_score", 32'(score), 32'd1);
        check("spc_collision", 32'(collision), 32'd0);
        check("spc_state", 32'(state), 32'd1);

        do_reset();
        go();
        bird_row = 4'd12;
        for (int k = 0; k < 12; k++) begin
            w = ((k % 6) == 0) ? 16'h1FFF : 16'hFFFF;
            pulse(w, (k % 6) == 0, "crs_wall_req");
        end
        check("pre_crash_state", 32'(state), 32'd1);
        check("pre_crash_coll", 32'(collision), 32'd0);
        pulse(16'h1FFF, 1'b1, "crs_last_req");
        check("crash_state", 32'(state), 32'd2);
        check("crash_collision", 32'(collision), 32'd1);
        check("crash_score", 32'(score), 32'd0);
        check_field("crash_field", 16'h1FFF, 16'h1FFF, 16'h1FFF);
        start = 1'b1;
        repeat (3) pulse(16'hC7FF, 1'b0, "crash_wall_req");
        start = 1'b0;
        check("crash_hold_state", 32'(state), 32'd2);
        check("crash_hold_coll", 32'(collision), 32'd1);
        check("crash_hold_score", 32'(score), 32'd0);
        check("crash_hold_gap", 32'(gap_top), 32'd13);
        check_field("crash_hold_field", 16'h1FFF, 16'h1FFF, 16'h1FFF);

        do_reset();
        go();
        bird_row = 4'd14;
        run_ticks(12);
        check("score_before", 32'(score), 32'd0);
        run_ticks(1);
        check("score_pass", 32'(score), 32'd1);
        check("score_no_coll", 32'(collision), 32'd0);
        run_ticks(1523);
        check("score_fe", 32'(score), 32'hFE);
        run_ticks(1);
        check("score_ff", 32'(score), 32'hFF);
        run_ticks(12);
        check("score_sat", 32'(score), 32'hFF);
        check("score_sat_state", 32'(state), 32'd1);

        Reset = 1'b1;
        tick  = 1'b1;
        step();
        Reset = 1'b0;
        #1;
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_score", 32'(score), 32'd0);
        check("mid_rst_coll", 32'(collision), 32'd0);
        check("mid_rst_gap_top", 32'(gap_top), 32'd0);
        check("mid_rst_wall_req", 32'(wall_req), 32'd0);
        tick = 1'b0;
        check_field("mid_rst_field", 16'h0, 16'h0, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
